// File: rtl/mem_responder.sv
// Multicycle word memory responder with a fixed-latency request/ready handshake.
// Optional MEM_ALIGN_CHECK_EN: a misaligned captured address is treated as an error.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          capture;
    logic          do_write;
    logic [AW-1:0] idx;
    logic          range_err;
    logic          acc_err;

    logic [31:0]   mem_q [DEPTH_WORDS];

    assign idx       = addr_q[AW+1:2];
    assign range_err = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);

`ifdef MEM_ALIGN_CHECK_EN
    assign acc_err = range_err | (addr_q[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^addr_q[1:0];
    assign acc_err    = range_err;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        capture  = 1'b0;
        do_write = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    capture = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // completion edge: perform the access
                    state_d = S_RESP;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    err_d   = acc_err;
                    if (wr_q) begin
                        do_write = !acc_err;
                    end else begin
                        rdata_d = acc_err ? 32'h0 : mem_q[idx];
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            wr_q    <= mem_wr;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    // contents are not reset; reset only suppresses a pending commit
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: cycle model of the primary instance plus
// directed transfers with literal expectations.
module tb_mem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;

    logic        d0_req, d0_wr;
    logic [31:0] d0_addr, d0_wdata, d0_rdata;
    logic        d0_ready, d0_busy, d0_err;

    logic        d1_req, d1_wr;
    logic [31:0] d1_addr, d1_wdata, d1_rdata;
    logic        d1_ready, d1_busy, d1_err;

    int n_chk;
    int n_fail;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut0 (
        .clk(clk), .reset(reset),
        .mem_req(d0_req), .mem_wr(d0_wr),
        .mem_addr(d0_addr), .mem_wdata(d0_wdata),
        .mem_rdata(d0_rdata), .mem_ready(d0_ready),
        .mem_busy(d0_busy), .addr_err(d0_err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .mem_req(d1_req), .mem_wr(d1_wr),
        .mem_addr(d1_addr), .mem_wdata(d1_wdata),
        .mem_rdata(d1_rdata), .mem_ready(d1_ready),
        .mem_busy(d1_busy), .addr_err(d1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: counts edges since acceptance; access happens LAT edges later
    int          m_phase;
    logic        m_valid;
    logic        m_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_err;
    logic [31:0] mm [DEPTH];

    initial m_valid = 1'b0;

    always @(posedge clk) begin : model
        int   ph;
        logic bad;
        ph = m_phase;
        if (reset) begin
            m_phase <= -1;
            m_rdata <= 32'h0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else if (ph < 0) begin
            if (d0_req) begin
                m_phase <= 0;
                m_wr    <= d0_wr;
                m_addr  <= d0_addr;
                m_wdata <= d0_wdata;
            end
        end else begin
            ph = ph + 1;
            if (ph == LAT) begin
                bad = (m_addr >> 2) >= DEPTH;
`ifdef MEM_ALIGN_CHECK_EN
                bad = bad || (m_addr % 4 != 0);
`endif
                m_err <= bad;
                if (m_wr) begin
                    if (!bad) mm[m_addr[9:2]] <= m_wdata;
                end else begin
                    m_rdata <= bad ? 32'h0 : mm[m_addr[9:2]];
                end
                m_phase <= ph;
            end else if (ph > LAT) begin
                m_phase <= -1;
            end else begin
                m_phase <= ph;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy", 32'(d0_busy),
                32'(m_phase >= 0 && m_phase < LAT));
            chk("cyc_ready", 32'(d0_ready), 32'(m_phase == LAT));
            chk("cyc_err", 32'(d0_err),
                32'(m_phase == LAT && m_err));
            chk("cyc_rdata", d0_rdata, m_rdata);
        end
    end

    task automatic xfer(input bit u1, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        if (u1) begin
            d1_req = 1'b1; d1_wr = wr; d1_addr = a; d1_wdata = wd;
        end else begin
            d0_req = 1'b1; d0_wr = wr; d0_addr = a; d0_wdata = wd;
        end
        @(negedge clk);
        // scramble captured fields to show they no longer matter
        if (u1) begin
            d1_req = 1'b0; d1_wr = ~wr; d1_addr = ~a; d1_wdata = ~wd;
            chk("accept_busy", 32'(d1_busy), 32'd1);
        end else begin
            d0_req = 1'b0; d0_wr = ~wr; d0_addr = ~a; d0_wdata = ~wd;
            chk("accept_busy", 32'(d0_busy), 32'd1);
        end
        lat = 0;
        while (!(u1 ? d1_ready : d0_ready) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: no ready within 20 cycles");
        end
        rd = u1 ? d1_rdata : d0_rdata;
        er = u1 ? d1_err : d0_err;
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rcnt;
        int          bcnt;
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        d0_req = 0; d0_wr = 0; d0_addr = 0; d0_wdata = 0;
        d1_req = 0; d1_wr = 0; d1_addr = 0; d1_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(d0_busy), 32'd0);
        chk("rst_ready", 32'(d0_ready), 32'd0);
        chk("rst_err", 32'(d0_err), 32'd0);
        chk("rst_rdata", d0_rdata, 32'h0);
        reset = 1'b0;

        xfer(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("t1_lat", 32'(lat), 32'd3);
        chk("t1_err", 32'(er), 32'd0);
        chk("t1_rdata_kept", rd, 32'h0);

        xfer(0, 0, 32'h10, 32'h0, rd, er, lat);
        chk("t2_rdata", rd, 32'hDEADBEEF);
        chk("t2_lat", 32'(lat), 32'd3);
        @(negedge clk);
        chk("t2_hold", d0_rdata, 32'hDEADBEEF);
        chk("t2_ready_pulse", 32'(d0_ready), 32'd0);

        xfer(0, 0, 32'h12, 32'h0, rd, er, lat);
`ifdef MEM_ALIGN_CHECK_EN
        chk("t6_err", 32'(er), 32'd1);
        chk("t6_rdata", rd, 32'h0);
`else
        chk("t6_err", 32'(er), 32'd0);
        chk("t6_rdata", rd, 32'hDEADBEEF);
`endif

        xfer(0, 1, 32'h0, 32'hCAFEF00D, rd, er, lat);
        xfer(0, 0, 32'h400, 32'h0, rd, er, lat);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", rd, 32'h0);
        chk("t4_lat", 32'(lat), 32'd3);
        xfer(0, 1, 32'h400, 32'h11111111, rd, er, lat);
        chk("t4_werr", 32'(er), 32'd1);
        xfer(0, 0, 32'h0, 32'h0, rd, er, lat);
        chk("t4_idx0", rd, 32'hCAFEF00D);
        chk("t4_idx0_err", 32'(er), 32'd0);

        @(negedge clk);
        d0_req = 1'b1; d0_wr = 1'b0; d0_addr = 32'h10;
        rcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d0_ready) rcnt++;
            if (d0_busy) bcnt++;
            d0_addr = (i % 2 == 1) ? 32'h10 : 32'h0;
            d0_wdata = 32'(i);
        end
        d0_req = 1'b0;
        chk("t3_ready_cnt", 32'(rcnt), 32'd4);
        chk("t3_busy_cnt", 32'(bcnt), 32'd12);

        xfer(0, 1, 32'h20, 32'hAAAA5555, rd, er, lat);
        @(negedge clk);
        d0_req = 1'b1; d0_wr = 1'b1;
        d0_addr = 32'h20; d0_wdata = 32'h12345678;
        @(negedge clk);
        d0_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_ready", 32'(d0_ready), 32'd0);
        chk("t5_busy", 32'(d0_busy), 32'd0);
        chk("t5_rdata", d0_rdata, 32'h0);
        reset = 1'b0;
        xfer(0, 0, 32'h20, 32'h0, rd, er, lat);
        chk("t5_old", rd, 32'hAAAA5555);

        xfer(1, 1, 32'h8, 32'h00005A5A, rd, er, lat);
        chk("t7_wlat", 32'(lat), 32'd1);
        xfer(1, 0, 32'h8, 32'h0, rd, er, lat);
        chk("t7_rlat", 32'(lat), 32'd1);
        chk("t7_rdata", rd, 32'h00005A5A);
        chk("t7_err", 32'(er), 32'd0);
        @(negedge clk);
        chk("t7_idle", 32'(d1_busy | d1_ready), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
